// File: rtl/spi_flash_responder_if.sv
// SPI target bus and byte-wide backing-memory port of spi_flash_responder.
interface spi_flash_responder_if #(
    parameter int unsigned ADDR_BITS = 20
);
    logic                 spi_csel;
    logic                 spi_clk;
    logic                 spi_mosi;
    logic                 spi_miso;
    logic                 spi_miso_oe;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_rd;
    logic [7:0]           mem_rdata;
    logic                 mem_wr;
    logic [7:0]           mem_wdata;
    logic                 mem_sec;
    logic                 busy;

    modport slave (
        input  spi_csel, spi_clk, spi_mosi, mem_rdata,
        output spi_miso, spi_miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata, mem_sec, busy
    );

    modport master (
        output spi_csel, spi_clk, spi_mosi, mem_rdata,
        input  spi_miso, spi_miso_oe, mem_addr, mem_rd, mem_wr, mem_wdata, mem_sec, busy
    );
endinterface

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI target emulating a W25Q-style NOR flash over a byte-wide memory port.
// Optional security-register opcodes 0x48/0x42/0x44: define SPI_FLASH_RESPONDER_SECURITY_EN.
module spi_flash_responder #(
    parameter int unsigned ADDR_BITS   = 20,
    parameter int unsigned PAGE_SIZE   = 256,
    parameter int unsigned ERASE_SIZE  = 4096,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    spi_flash_responder_if.slave bus
);
`ifdef SPI_FLASH_RESPONDER_SECURITY_EN
    localparam bit SEC_EN = 1'b1;
`else
    localparam bit SEC_EN = 1'b0;
`endif
    localparam int unsigned EC_W = $clog2(ERASE_SIZE) + 1;
    localparam logic [ADDR_BITS-1:0] PAGE_MASK  = ADDR_BITS'(PAGE_SIZE - 1);
    localparam logic [ADDR_BITS-1:0] ERASE_MASK = ADDR_BITS'(ERASE_SIZE - 1);

    typedef enum logic [3:0] {
        IDLE, CMD, ADDR, DUMMY, READ, STATUS, PROG, ERASE_WAIT, IGNORE
    } state_t;
    typedef enum logic [1:0] {OP_READ, OP_FAST, OP_PROG, OP_ERASE} op_t;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic cs_s, sck_s, mosi_s, sck_prev, rise, fall;

    state_t               state;
    op_t                  op;
    logic                 op_sec;
    logic [2:0]           bit_cnt, byte_cnt;
    logic [6:0]           rx;
    logic [ADDR_BITS-2:0] addr_sh;
    logic [7:0]           tx, rx_byte, sr1;
    logic [ADDR_BITS-1:0] addr_next;
    logic                 wel, wip, prog_written, erase_bad, rd_d1, erase_sec;
    logic [ADDR_BITS-1:0] erase_base;
    logic [EC_W-1:0]      erase_cnt, erase_len;
    logic                 miso, miso_oe, mem_rd, mem_wr, sec_q;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_wdata;

    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sck_s     = sck_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign rise      = sck_s & ~sck_prev;
    assign fall      = ~sck_s & sck_prev;
    assign rx_byte   = {rx, mosi_s};
    assign addr_next = {addr_sh, mosi_s};
    assign sr1       = {6'b0, wel, wip};

    assign bus.spi_miso    = miso;
    assign bus.spi_miso_oe = miso_oe;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_rd      = mem_rd;
    assign bus.mem_wr      = mem_wr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.mem_sec     = SEC_EN & sec_q;
    assign bus.busy        = wip;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync   <= '1;
            sck_sync  <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
        end else begin
            cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(bus.spi_csel);
            sck_sync  <= (sck_sync << 1) | SYNC_STAGES'(bus.spi_clk);
            mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(bus.spi_mosi);
            sck_prev  <= sck_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;       op <= OP_READ;        op_sec <= 1'b0;
            bit_cnt <= '0;       byte_cnt <= '0;       rx <= '0;
            addr_sh <= '0;       tx <= '0;             wel <= 1'b0;
            wip <= 1'b0;         prog_written <= 1'b0; erase_bad <= 1'b0;
            rd_d1 <= 1'b0;       erase_base <= '0;     erase_cnt <= '0;
            erase_len <= '0;     erase_sec <= 1'b0;    miso <= 1'b0;
            miso_oe <= 1'b0;     mem_rd <= 1'b0;       mem_wr <= 1'b0;
            mem_addr <= '0;      mem_wdata <= '0;      sec_q <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            sec_q  <= 1'b0;
            rd_d1  <= mem_rd;
            if (cs_s) begin
                // CS high ends any transaction; commit-on-release actions fire here once.
                if (state == PROG && prog_written)
                    wel <= 1'b0;
                if (state == ERASE_WAIT && !erase_bad && wel) begin
                    wip        <= 1'b1;
                    erase_cnt  <= '0;
                    erase_sec  <= op_sec;
                    erase_base <= mem_addr & ~(op_sec ? PAGE_MASK : ERASE_MASK);
                    erase_len  <= op_sec ? EC_W'(PAGE_SIZE) : EC_W'(ERASE_SIZE);
                end
                state   <= IDLE;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
            end else if (state == IDLE) begin
                state    <= CMD;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                miso_oe  <= 1'b1;
                miso     <= 1'b0;
            end else begin
                if (rd_d1 && state == READ)
                    tx <= bus.mem_rdata;
                if (rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx      <= rx_byte[6:0];
                    addr_sh <= addr_next[ADDR_BITS-2:0];
                    if (state == ERASE_WAIT)
                        erase_bad <= 1'b1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt != 3'd7)
                            byte_cnt <= byte_cnt + 3'd1;
                        case (state)
                            CMD: begin
                                state  <= IGNORE;
                                op_sec <= 1'b0;
                                if (rx_byte == 8'h05) begin
                                    state <= STATUS;
                                    tx    <= sr1;
                                end else if (!wip) begin
                                    case (rx_byte)
                                        8'h06: wel <= 1'b1;
                                        8'h04: wel <= 1'b0;
                                        8'h03: begin op <= OP_READ;  state <= ADDR; end
                                        8'h0B: begin op <= OP_FAST;  state <= ADDR; end
                                        8'h02: begin op <= OP_PROG;  state <= ADDR; end
                                        8'h20: begin op <= OP_ERASE; state <= ADDR; end
                                        8'h48: if (SEC_EN) begin op <= OP_FAST;  op_sec <= 1'b1; state <= ADDR; end
                                        8'h42: if (SEC_EN) begin op <= OP_PROG;  op_sec <= 1'b1; state <= ADDR; end
                                        8'h44: if (SEC_EN) begin op <= OP_ERASE; op_sec <= 1'b1; state <= ADDR; end
                                        default: ;
                                    endcase
                                end
                            end
                            ADDR: if (byte_cnt == 3'd3) begin
                                mem_addr <= addr_next;
                                case (op)
                                    OP_READ: begin state <= READ; mem_rd <= 1'b1; sec_q <= op_sec; end
                                    OP_FAST: state <= DUMMY;
                                    OP_PROG: begin state <= wel ? PROG : IGNORE; prog_written <= 1'b0; end
                                    default: begin state <= ERASE_WAIT; erase_bad <= 1'b0; end
                                endcase
                            end
                            DUMMY: begin
                                state  <= READ;
                                mem_rd <= 1'b1;
                                sec_q  <= op_sec;
                            end
                            READ: begin
                                mem_addr <= mem_addr + 1'b1;
                                mem_rd   <= 1'b1;
                                sec_q    <= op_sec;
                            end
                            STATUS: tx <= sr1;
                            PROG: begin
                                mem_wr       <= 1'b1;
                                mem_wdata    <= rx_byte;
                                sec_q        <= op_sec;
                                prog_written <= 1'b1;
                                // First byte lands at the start address; later ones advance within the page.
                                if (prog_written)
                                    mem_addr <= (mem_addr & ~PAGE_MASK) | ((mem_addr + 1'b1) & PAGE_MASK);
                            end
                            default: ;
                        endcase
                    end
                end
                if (fall)
                    miso <= (state == READ || state == STATUS) ? tx[~bit_cnt] : 1'b0;
            end
            // Erase engine runs regardless of CS; transactions cannot touch memory while WIP is set.
            if (wip) begin
                if (erase_cnt == erase_len) begin
                    wip <= 1'b0;
                    wel <= 1'b0;
                end else begin
                    mem_wr    <= 1'b1;
                    mem_wdata <= 8'hFF;
                    mem_addr  <= erase_base | ADDR_BITS'(erase_cnt);
                    erase_cnt <= erase_cnt + 1'b1;
                    sec_q     <= erase_sec;
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed self-checking bench for spi_flash_responder with a behavioural byte memory.
module tb_spi_flash_responder;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_flash_responder_if #(.ADDR_BITS(20)) bus ();

    spi_flash_responder #(
        .ADDR_BITS(20), .PAGE_SIZE(256), .ERASE_SIZE(4096), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [7:0]  mem [0:(1<<20)-1];
    logic        pre_we = 1'b0;
    logic [19:0] pre_addr = '0;
    logic [7:0]  pre_data = '0;
    logic [7:0]  rdata = '0;
    assign bus.mem_rdata = rdata;

    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) rdata <= mem[bus.mem_addr];
    end

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
        logic        sec;
    } wr_t;
    wr_t  wr_log[$];
    int   rd_count = 0;
    logic collision = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_wr) wr_log.push_back({bus.mem_addr, bus.mem_wdata, bus.mem_sec});
            if (bus.mem_rd) rd_count++;
            if (bus.mem_rd && bus.mem_wr) collision = 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [19:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] d, output logic [7:0] r);
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            bus.spi_mosi = d[i];
            repeat (HALF) @(negedge clk);
            r[i] = bus.spi_miso;
            bus.spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic spi_bits(input logic [23:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bus.spi_mosi = d[i];
            repeat (HALF) @(negedge clk);
            bus.spi_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.spi_csel = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        bus.spi_csel = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic cmd1(input logic [7:0] opc);
        logic [7:0] j;
        cs_low();
        spi_byte(opc, j);
        cs_high();
    endtask

    task automatic cmd_addr(input logic [7:0] opc, input logic [23:0] a);
        logic [7:0] j;
        spi_byte(opc, j);
        spi_byte(a[23:16], j);
        spi_byte(a[15:8], j);
        spi_byte(a[7:0], j);
    endtask

    task automatic status_read(output logic [7:0] r);
        logic [7:0] j;
        cs_low();
        spi_byte(8'h05, j);
        spi_byte(8'h00, r);
        cs_high();
    endtask

    initial begin
        logic [7:0] r0, r1, r2;
        int base_idx, n_wr, bad, rd0, n;

        bus.spi_csel = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_miso",    32'(bus.spi_miso),    0);
        check("rst_oe",      32'(bus.spi_miso_oe), 0);
        check("rst_rd",      32'(bus.mem_rd),      0);
        check("rst_wr",      32'(bus.mem_wr),      0);
        check("rst_addr",    32'(bus.mem_addr),    0);
        check("rst_wdata",   32'(bus.mem_wdata),   0);
        check("rst_sec",     32'(bus.mem_sec),     0);
        check("rst_busy",    32'(bus.busy),        0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // WEL set/clear seen through SR1
        cmd1(8'h06);
        cs_low();
        check("oe_active", 32'(bus.spi_miso_oe), 1);
        spi_byte(8'h05, r0);
        spi_byte(8'h00, r1);
        spi_byte(8'h00, r2);
        cs_high();
        check("sr1_wel_b0", 32'(r1), 32'h02);
        check("sr1_wel_b1", 32'(r2), 32'h02);
        check("oe_idle", 32'(bus.spi_miso_oe), 0);
        cmd1(8'h04);
        status_read(r0);
        check("sr1_wrdi", 32'(r0), 32'h00);

        // program without WEL is ignored
        n_wr = wr_log.size();
        cs_low();
        cmd_addr(8'h02, 24'h000100);
        spi_byte(8'hA5, r0);
        cs_high();
        check("prog_nowel_wr", 32'(wr_log.size() - n_wr), 0);
        status_read(r0);
        check("prog_nowel_sr1", 32'(r0), 32'h00);

        // page-wrapping program
        cmd1(8'h06);
        n_wr = wr_log.size();
        cs_low();
        cmd_addr(8'h02, 24'h0001FE);
        spi_byte(8'h11, r0);
        spi_byte(8'h22, r0);
        spi_byte(8'h33, r0);
        cs_high();
        check("prog_wr_count", 32'(wr_log.size() - n_wr), 3);
        if (wr_log.size() - n_wr == 3) begin
            check("prog_wr0", 32'({wr_log[n_wr].addr,   wr_log[n_wr].data,   wr_log[n_wr].sec}),   32'({20'h001FE, 8'h11, 1'b0}));
            check("prog_wr1", 32'({wr_log[n_wr+1].addr, wr_log[n_wr+1].data, wr_log[n_wr+1].sec}), 32'({20'h001FF, 8'h22, 1'b0}));
            check("prog_wr2", 32'({wr_log[n_wr+2].addr, wr_log[n_wr+2].data, wr_log[n_wr+2].sec}), 32'({20'h00100, 8'h33, 1'b0}));
        end
        status_read(r0);
        check("prog_sr1_after", 32'(r0), 32'h00);

        // fast read and plain read
        preload(20'h01230, 8'hDE);
        preload(20'h01231, 8'hAD);
        preload(20'h01232, 8'hBE);
        cs_low();
        cmd_addr(8'h0B, 24'h001230);
        spi_byte(8'h00, r0);
        spi_byte(8'h00, r0);
        spi_byte(8'h00, r1);
        spi_byte(8'h00, r2);
        cs_high();
        check("fast_rd0", 32'(r0), 32'hDE);
        check("fast_rd1", 32'(r1), 32'hAD);
        check("fast_rd2", 32'(r2), 32'hBE);
        cs_low();
        cmd_addr(8'h03, 24'h001230);
        spi_byte(8'h00, r0);
        spi_byte(8'h00, r1);
        spi_byte(8'h00, r2);
        cs_high();
        check("read_rd0", 32'(r0), 32'hDE);
        check("read_rd1", 32'(r1), 32'hAD);
        check("read_rd2", 32'(r2), 32'hBE);

        // sector erase with polls and a blocked read
        preload(20'h00FFF, 8'h5A);
        preload(20'h02000, 8'h6B);
        cmd1(8'h06);
        base_idx = wr_log.size();
        cs_low();
        cmd_addr(8'h20, 24'h001234);
        cs_high();
        check("erase_busy", 32'(bus.busy), 1);
        status_read(r0);
        check("erase_sr1_poll", 32'(r0), 32'h03);
        rd0 = rd_count;
        cs_low();
        cmd_addr(8'h03, 24'h001230);
        spi_byte(8'h00, r1);
        cs_high();
        check("erase_blocked_rd", 32'(rd_count - rd0), 0);
        check("erase_blocked_miso", 32'(r1), 32'h00);
        status_read(r0);
        check("erase_sr1_poll2", 32'(r0), 32'h03);
        for (n = 0; n < 6000 && bus.busy; n++) @(negedge clk);
        check("erase_done", 32'(bus.busy), 0);
        check("erase_wr_count", 32'(wr_log.size() - base_idx), 4096);
        bad = 0;
        for (int i = 0; i < 4096 && base_idx + i < wr_log.size(); i++) begin
            if (wr_log[base_idx+i].addr != 20'(32'h1000 + i) ||
                wr_log[base_idx+i].data != 8'hFF || wr_log[base_idx+i].sec != 1'b0)
                bad++;
        end
        check("erase_seq", 32'(bad), 0);
        check("erase_mem_in",  32'(mem[20'h01230]), 32'hFF);
        check("erase_mem_lo",  32'(mem[20'h00FFF]), 32'h5A);
        check("erase_mem_hi",  32'(mem[20'h02000]), 32'h6B);
        status_read(r0);
        check("erase_sr1_end", 32'(r0), 32'h00);

        // program aborted after 12 address bits
        cmd1(8'h06);
        n_wr = wr_log.size();
        cs_low();
        spi_byte(8'h02, r0);
        spi_bits(24'h000, 12);
        cs_high();
        check("abort_oe", 32'(bus.spi_miso_oe), 0);
        check("abort_wr", 32'(wr_log.size() - n_wr), 0);
        status_read(r0);
        check("abort_sr1", 32'(r0), 32'h02);

        // reset mid-erase
        cs_low();
        cmd_addr(8'h20, 24'h003000);
        cs_high();
        repeat (100) @(negedge clk);
        check("rst_erase_busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_erase_idle", 32'(bus.busy), 0);
        reset = 1'b0;
        @(negedge clk);
        n_wr = wr_log.size();
        repeat (20) @(negedge clk);
        check("rst_erase_stop", 32'(wr_log.size() - n_wr), 0);
        status_read(r0);
        check("rst_erase_sr1", 32'(r0), 32'h00);

        check("no_rd_wr_overlap", 32'(collision), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
